datapath_run_ctrl: RTL and testbench

- Programmable run controller for the multi-cycle datapath (Fase Final and later phases).
- Replaces fixed hand-toggled clock sequences with a synthesizable clock-enable sequencer.
- Supports fixed-count, free-run and single-step modes, a programmable enable divider, and halt/stop detection with a recorded stop cause.
- Sits between the board/bench control inputs and the datapath clock-enable input.

---
 rtl/datapath_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_datapath_run_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_run_ctrl.sv
// Run controller: sequences the datapath clock enable in fixed-count, free-run or single-step mode.
// Latency: first ce one clock after RUN entry; ce pulses spaced div+1 clocks; ce/busy/done are registered.
// Backpressure: stop/halt_req end a run on the next edge; start is ignored while busy.
module datapath_run_ctrl #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [DIV_W-1:0] div,
  input  logic             halt_req,
  output logic             ce,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       cause
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_FREE  = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_STOP  = 2'd2;
  localparam logic [1:0] CAUSE_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] limit_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;

  logic [CNT_W-1:0] cycles_nxt;
  logic [CNT_W-1:0] cycles_sat;

  // Next count value; saturating form is used for the issued-enable counter,
  // the raw form for the limit compare (mode 0 hits its limit before wrapping).
  assign cycles_nxt = cycles + CNT_ONE;
  assign cycles_sat = (cycles == CNT_MAX) ? cycles : cycles_nxt;

  // Single FSM: state, latched run setup, divider and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_FIXED;
      limit_q <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      ce      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cycles  <= '0;
      cause   <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          ce <= 1'b0;
          if (start && !stop) begin
            // Mode 3 behaves as fixed count.
            mode_q  <= (mode == 2'd3) ? MODE_FIXED : mode;
            limit_q <= cycle_limit;
            div_q   <= div;
            div_cnt <= '0;
            cycles  <= '0;
            cause   <= CAUSE_NONE;
            if (mode == MODE_STEP) begin
              state <= STEP;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else if (mode != MODE_FREE && cycle_limit == '0) begin
              // Zero-length fixed run completes without issuing any enable.
              state <= DONE;
              cause <= CAUSE_LIMIT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end

        RUN: begin
          if (stop) begin
            state <= DONE;
            cause <= CAUSE_STOP;
            ce    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (halt_req) begin
            state <= DONE;
            cause <= CAUSE_HALT;
            ce    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (div_cnt == '0) begin
            ce      <= 1'b1;
            cycles  <= cycles_sat;
            div_cnt <= div_q;
            // The final enable of a fixed run is still issued on this edge.
            if (mode_q == MODE_FIXED && cycles_nxt == limit_q) begin
              state <= DONE;
              cause <= CAUSE_LIMIT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            ce      <= 1'b0;
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        STEP: begin
          if (stop) begin
            state <= DONE;
            cause <= CAUSE_STOP;
            ce    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (halt_req) begin
            state <= DONE;
            cause <= CAUSE_HALT;
            ce    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step && !ce) begin
            // A held step yields a pulse every other clock.
            ce     <= 1'b1;
            cycles <= cycles_sat;
          end else begin
            ce <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          ce    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison is an immediate assertion that counts and reports failures.
module tb_datapath_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        step;
  logic [1:0]  mode;
  logic [15:0] cycle_limit;
  logic [7:0]  div;
  logic        halt_req;
  logic        ce;
  logic        busy;
  logic        done;
  logic [15:0] cycles;
  logic [1:0]  cause;

  int n_checks = 0;
  int n_fails  = 0;

  datapath_run_ctrl #(.CNT_W(16), .DIV_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .mode        (mode),
    .cycle_limit (cycle_limit),
    .div         (div),
    .halt_req    (halt_req),
    .ce          (ce),
    .busy        (busy),
    .done        (done),
    .cycles      (cycles),
    .cause       (cause)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 2'd0;
    cycle_limit = 16'd0; div = 8'd0; halt_req = 1'b0;
    #2;
    chk("rst_ce", {31'b0, ce}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cycles", {16'b0, cycles}, 32'd0);
    chk("rst_cause", {30'b0, cause}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a fixed run.
    mode = 2'd0; cycle_limit = 16'd5; div = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_entry_busy", {31'b0, busy}, 32'd1);
    chk("t1_entry_ce", {31'b0, ce}, 32'd0);
    tick(); tick();
    chk("t1_two_cycles", {16'b0, cycles}, 32'd2);
    chk("t1_two_ce", {31'b0, ce}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_ce", {31'b0, ce}, 32'd0);
    chk("t1_rst_cycles", {16'b0, cycles}, 32'd0);
    chk("t1_rst_busy", {31'b0, busy}, 32'd0);
    tick(); rst_n = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_ce_run", {31'b0, ce}, 32'd1);
    end
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_busy_low", {31'b0, busy}, 32'd0);
    chk("t1_cause", {30'b0, cause}, 32'd1);
    chk("t1_cycles", {16'b0, cycles}, 32'd5);
    tick();
    chk("t1_ce_after", {31'b0, ce}, 32'd0);

    // Divider: pulses on clocks 1, 4, 7 after RUN entry (restart from DONE).
    mode = 2'd0; cycle_limit = 16'd3; div = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_cycles_clr", {16'b0, cycles}, 32'd0);
    chk("t2_cause_clr", {30'b0, cause}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_ce", {31'b0, ce}, (k == 1 || k == 4 || k == 7) ? 32'd1 : 32'd0);
      chk("t2_done", {31'b0, done}, (k >= 7) ? 32'd1 : 32'd0);
    end
    chk("t2_cycles", {16'b0, cycles}, 32'd3);

    // Zero limit: straight to DONE, no enable.
    mode = 2'd0; cycle_limit = 16'd0; div = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_cause", {30'b0, cause}, 32'd1);
    chk("t3_ce", {31'b0, ce}, 32'd0);
    chk("t3_cycles", {16'b0, cycles}, 32'd0);
    tick();
    chk("t3_ce2", {31'b0, ce}, 32'd0);

    // start together with stop in IDLE does nothing.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mode = 2'd1; start = 1'b1; stop = 1'b1;
    tick();
    chk("t6_ss_busy", {31'b0, busy}, 32'd0);
    chk("t6_ss_done", {31'b0, done}, 32'd0);
    start = 1'b0; stop = 1'b0;
    tick();
    chk("t6_ss_ce", {31'b0, ce}, 32'd0);

    // Free run, start ignored mid-run, halt after 7 enables.
    mode = 2'd1; div = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin
        mode = 2'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("t4_ce", {31'b0, ce}, 32'd1);
      chk("t4_cycles_run", {16'b0, cycles}, k);
    end
    start = 1'b0;
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    chk("t4_ce_halt", {31'b0, ce}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd1);
    chk("t4_cause", {30'b0, cause}, 32'd3);
    chk("t4_cycles", {16'b0, cycles}, 32'd7);

    // stop and halt_req on the same edge: stop wins.
    mode = 2'd1; div = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    stop = 1'b1; halt_req = 1'b1;
    tick(); stop = 1'b0; halt_req = 1'b0;
    chk("t6_sh_cause", {30'b0, cause}, 32'd2);
    chk("t6_sh_cycles", {16'b0, cycles}, 32'd1);
    chk("t6_sh_ce", {31'b0, ce}, 32'd0);

    // Single step: isolated pulses, then held step, then stop.
    mode = 2'd2; div = 8'd5; cycle_limit = 16'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd1);
    chk("t5_entry_ce", {31'b0, ce}, 32'd0);
    tick();
    chk("t5_idle_ce", {31'b0, ce}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick();
      chk("t5_iso_hi", {31'b0, ce}, 32'd1);
      step = 1'b0; tick();
      chk("t5_iso_lo", {31'b0, ce}, 32'd0);
      tick();
    end
    chk("t5_cycles3", {16'b0, cycles}, 32'd3);
    step = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_held", {31'b0, ce}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    step = 1'b0;
    tick();
    chk("t5_busy_still", {31'b0, busy}, 32'd1);
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("t5_done", {31'b0, done}, 32'd1);
    chk("t5_cause", {30'b0, cause}, 32'd2);
    chk("t5_cycles", {16'b0, cycles}, 32'd6);
    tick();
    chk("t5_hold_cycles", {16'b0, cycles}, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
